// File: rtl/alu_operand_sel.sv
// -----------------------------------------------------------------------------
// alu_operand_sel
//   Registered operand-A select stage for the accumulator ALU datapath.
//   Chooses one of NUM_SRC register sources, a constant, an extended immediate
//   or the forwarded ALU result, and holds it in a one-entry valid/ready output
//   stage so the operand stays steady while the ALU stalls. Illegal select
//   codes complete as a zero operand and set a sticky error flag.
//
// Ports
//   CLK        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   op         in   [SEL_W-1:0]         select code
//   src_flat   in   [NUM_SRC*WIDTH-1:0] packed register sources
//   imm        in   [IMM_W-1:0]         immediate field
//   imm_sext   in   1 = sign-extend imm, 0 = zero-extend
//   in_valid   in   capture request
//   in_ready   out  stage can accept a request
//   res_we     in   ALU result write strobe
//   res_data   in   [WIDTH-1:0]         ALU result
//   out_valid  out  mux_out holds a valid operand
//   out_ready  in   ALU consumes mux_out this cycle
//   mux_out    out  [WIDTH-1:0]         registered operand
//   err        out  sticky illegal-select flag
//   err_clr    in   clears err (an illegal accept in the same cycle wins)
// -----------------------------------------------------------------------------
module alu_operand_sel #(
  parameter int          WIDTH     = 16,
  parameter int          NUM_SRC   = 3,
  parameter int          SEL_W     = 3,
  parameter int          IMM_W     = 8,
  parameter int unsigned CONST_VAL = 32'd8
) (
  input  logic                       CLK,
  input  logic                       reset_n,
  input  logic [SEL_W-1:0]           op,
  input  logic [NUM_SRC*WIDTH-1:0]   src_flat,
  input  logic [IMM_W-1:0]           imm,
  input  logic                       imm_sext,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       res_we,
  input  logic [WIDTH-1:0]           res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           mux_out,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [SEL_W-1:0] CODE_CONST = SEL_W'(NUM_SRC);
  localparam logic [SEL_W-1:0] CODE_IMM   = SEL_W'(NUM_SRC + 1);
  localparam logic [SEL_W-1:0] CODE_FWD   = SEL_W'(NUM_SRC + 2);
  localparam logic [WIDTH-1:0] CONST_W    = WIDTH'(CONST_VAL);

  logic [WIDTH-1:0] w_src [NUM_SRC];
  logic [IDX_W-1:0] w_src_idx;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_sel_val;
  logic             w_illegal;
  logic             w_accept;
  logic             w_consume;

  logic [WIDTH-1:0] r_fwd;
  logic [WIDTH-1:0] r_mux_out;
  logic             r_out_valid;
  logic             r_err;

  // Unpack the flat source bus into an indexable array.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_src[k] = src_flat[k*WIDTH +: WIDTH];
  end

  // Low bits of op index the source array; only used when op < NUM_SRC.
  assign w_src_idx = op[IDX_W-1:0];

  // Casting through $signed gives sign extension without a replication that
  // would become zero-width when IMM_W == WIDTH.
  assign w_imm_ext = imm_sext ? WIDTH'($signed(imm)) : WIDTH'(imm);

  // Same-cycle write bypasses the forwarding register.
  assign w_fwd = res_we ? res_data : r_fwd;

  // One-entry stage without a skid buffer: accept only when empty or draining.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  // Operand select decode; unmatched codes produce zero and flag illegal.
  always_comb begin
    w_sel_val = {WIDTH{1'b0}};
    w_illegal = 1'b0;
    if (op < CODE_CONST) begin
      w_sel_val = w_src[w_src_idx];
    end else if (op == CODE_CONST) begin
      w_sel_val = CONST_W;
    end else if (op == CODE_IMM) begin
      w_sel_val = w_imm_ext;
    end else if (op == CODE_FWD) begin
      w_sel_val = w_fwd;
    end else begin
      w_illegal = 1'b1;
    end
  end

  // Forwarding register tracks every ALU write regardless of the handshake.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd <= {WIDTH{1'b0}};
    end else if (res_we) begin
      r_fwd <= res_data;
    end
  end

  // Output stage: load on accept, drop valid on a consume with no new load.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_mux_out   <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_mux_out   <= w_sel_val;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky error: an illegal accept takes priority over a clear.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign mux_out   = r_mux_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule
